// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: FSM encodings and mult/div timing defaults.
// Imported by hazard_ctrl and md_timer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1
    } hc_state_e;

    localparam int MD_CYCLES_DEF = 32;
    localparam int MD_W          = 6;

endpackage

// File: rtl/md_timer.sv
// Mult/div latency down-counter: load starts a run of value+1 busy cycles;
// done flags the last busy cycle.
module md_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int W = MD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         busy,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load) begin
            cnt_d  = value;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch/jump flush, mult/div wait.
// Define HAZ_MULDIV_EN to build in the mult/div sequencing FSM.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        ex_rt,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              id_jump,
    input  logic              id_md_start,
    input  logic              id_md_use,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              md_busy,
    output logic [1:0]        state,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    logic load_use;
    logic md_stall;
    logic [STAT_W-1:0] stall_q, stall_d;
    logic [STAT_W-1:0] flush_q, flush_d;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

`ifdef HAZ_MULDIV_EN
    hc_state_e state_q, state_d;
    logic      issue;
    logic      md_done;
    logic      tmr_busy;

    // A flushed or stalled mult/div is dropped here and re-issues later.
    assign issue = (state_q == RUN) && id_md_start &&
                   !ex_branch_taken && !load_use;
    assign md_stall = (state_q == MD_WAIT) && id_md_use;

    md_timer #(
        .W(MD_W)
    ) u_md_timer (
        .clk  (clk),
        .rst  (rst),
        .load (issue),
        .value(MD_W'(MD_CYCLES - 1)),
        .busy (tmr_busy),
        .done (md_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (issue) state_d = MD_WAIT;
            MD_WAIT: if (md_done) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign state   = state_q;
    assign md_busy = tmr_busy;
`else
    logic unused_md;

    assign unused_md = ^{id_md_start, id_md_use, MD_W'(MD_CYCLES - 1)};
    assign md_stall  = 1'b0;
    assign state     = RUN;
    assign md_busy   = 1'b0;
`endif

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use || md_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_jump) begin
            ifid_flush  = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_write && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (ifid_flush && (flush_q != '1)) flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expected-value scoreboard queue.
// Follows HAZ_MULDIV_EN so expectations match the built configuration.
module tb_hazard_ctrl;

    localparam int MD_CYC = 4;
    localparam int SW     = 16;
`ifdef HAZ_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    typedef struct {
        logic        pc;
        logic        iw;
        logic        fl;
        logic        bb;
        logic        mb;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          ex_mem_read, ex_branch_taken, id_jump;
    logic          id_md_start, id_md_use;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble;
    logic          md_busy;
    logic [1:0]    state;
    logic [SW-1:0] stall_cnt, flush_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];

    int m_state = 0;
    int m_rem   = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MD_CYCLES(MD_CYC),
        .STAT_W   (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .ex_rt          (ex_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .id_jump        (id_jump),
        .id_md_start    (id_md_start),
        .id_md_use      (id_md_use),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .md_busy        (md_busy),
        .state          (state),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, predict, compare at negedge, advance model.
    task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ert, input logic mr, input logic br,
                       input logic jmp, input logic ms, input logic mu);
        exp_t e;
        exp_t o;
        logic lu, mw;
        rst = r; id_rs = rs; id_rt = rt; ex_rt = ert;
        ex_mem_read = mr; ex_branch_taken = br; id_jump = jmp;
        id_md_start = ms; id_md_use = mu;
        lu = mr && (ert != 5'd0) && (ert == rs || ert == rt);
        mw = MD_EN && (m_state == 1);
        if (!r) begin
            m_state = 0; m_rem = 0; m_stall = 0; m_flush = 0;
            e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'd0, 16'd0};
        end else begin
            e.mb = mw;
            e.st = 2'(m_state);
            e.sc = 16'(m_stall);
            e.fc = 16'(m_flush);
            {e.pc, e.iw, e.fl, e.bb} = 4'b1100;
            if (br)                 {e.pc, e.iw, e.fl, e.bb} = 4'b1111;
            else if (lu || (mw && mu)) {e.pc, e.iw, e.fl, e.bb} = 4'b0001;
            else if (jmp)           {e.pc, e.iw, e.fl, e.bb} = 4'b1110;
        end
        sbq.push_back(e);
        @(negedge clk);
        o = sbq.pop_front();
        chk("pc_write",    16'(pc_write),    16'(o.pc));
        chk("ifid_write",  16'(ifid_write),  16'(o.iw));
        chk("ifid_flush",  16'(ifid_flush),  16'(o.fl));
        chk("idex_bubble", 16'(idex_bubble), 16'(o.bb));
        chk("md_busy",     16'(md_busy),     16'(o.mb));
        chk("state",       16'(state),       16'(o.st));
        chk("stall_cnt",   16'(stall_cnt),   o.sc);
        chk("flush_cnt",   16'(flush_cnt),   o.fc);
        @(posedge clk);
        if (r) begin
            if (!o.pc && m_stall < 65535) m_stall++;
            if (o.fl && m_flush < 65535)  m_flush++;
            if (m_state == 0) begin
                if (MD_EN && ms && !br && !lu) begin
                    m_state = 1;
                    m_rem   = MD_CYC;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_state = 0;
            end
        end
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; id_jump = 1'b0;
        id_md_start = 1'b0; id_md_use = 1'b0;
        #1;
        // r  rs     rt     ert    mr br jmp ms mu
        cyc(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        cyc(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        cyc(1, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        cyc(1, 5'd2, 5'd7, 5'd7, 1, 0, 0, 0, 0);
        cyc(1, 5'd2, 5'd7, 5'd7, 0, 0, 0, 0, 0);
        cyc(1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        cyc(1, 5'd9, 5'd0, 5'd9, 1, 0, 1, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        for (int i = 0; i < MD_CYC + 2; i++)
            cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0);
        cyc(1, 5'd4, 5'd0, 5'd4, 1, 0, 0, 1, 0);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
        cyc(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++)
            cyc(1, 5'd3, 5'd0, 5'd3, 1, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        chk("stall_sat", 16'(stall_cnt), 16'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MD_CYCLES, default 32, legal range 2..64: issue-to-result latency of the multi-cycle mult/div unit.
REQ-002 The block SHALL have parameter STAT_W, default 16: width of the stall and flush statistics counters.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 ex_rt  in  5  destination rt held in the ID/EX stage register.
REQ-007 ex_mem_read  in  1  instruction in EX is a load.
REQ-008 ex_branch_taken  in  1  branch resolved taken in EX.
REQ-009 id_jump  in  1  jump decoded in ID.
REQ-010 id_md_start  in  1  mult/div decoded in ID.
REQ-011 id_md_use  in  1  ID instruction reads HI/LO (mfhi/mflo) or is another mult/div.
REQ-012 pc_write  out  1  PC load enable.
REQ-013 ifid_write  out  1  IF/ID register load enable.
REQ-014 ifid_flush  out  1  IF/ID contents replaced by a NOP.
REQ-015 idex_bubble  out  1  zero the WB/M/EX control fields entering ID/EX.
REQ-016 md_busy  out  1  mult/div in flight.
REQ-017 state  out  2  current FSM state.
REQ-018 stall_cnt, flush_cnt  out  STAT_W each  saturating event counters.

Function
REQ-019 The FSM SHALL have two states: RUN=0 and MD_WAIT=1. state SHALL drive the FSM encoding on its 2 bits; encodings 2 and 3 are unused.
REQ-020 The default outputs SHALL be pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-021 Load-use SHALL be detected as ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt).
REQ-022 Outputs SHALL be combinational from state and inputs, with the following priority in both states:
  (1) ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1.
  (2) load-use: pc_write=0, ifid_write=0, idex_bubble=1.
  (3) MD_WAIT && id_md_use: pc_write=0, ifid_write=0, idex_bubble=1.
  (4) id_jump: ifid_flush=1.
REQ-023 In RUN, id_md_start with no higher-priority event SHALL move the FSM to MD_WAIT at the next edge, load the timer with MD_CYCLES-1, and let the instruction issue.
REQ-024 id_md_start SHALL be ignored in a cycle that has a branch flush or a stall; the held instruction re-issues later.
REQ-025 In MD_WAIT, the timer SHALL decrement every cycle; at timer==0 the FSM SHALL return to RUN at the next edge.
REQ-026 md_busy SHALL be 1 exactly while in MD_WAIT, i.e. for MD_CYCLES cycles after issue.
REQ-027 A branch flush in MD_WAIT SHALL NOT cancel the in-flight mult/div.
REQ-028 stall_cnt SHALL increment on each cycle with pc_write=0.
REQ-029 flush_cnt SHALL increment on each cycle with ifid_flush=1.
REQ-030 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-031 While rst=0, outputs SHALL be forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
REQ-032 While rst=0, state SHALL be RUN, and timer, md_busy, stall_cnt and flush_cnt SHALL be 0, including when reset is asserted mid-MD_WAIT.
REQ-033 On the first edge after rst deasserts, the block SHALL operate from RUN with default outputs.

Configuration
REQ-034 Macro HAZ_MULDIV_EN defined: mult/div sequencing SHALL be present as specified in REQ-023..REQ-027.
REQ-035 Macro HAZ_MULDIV_EN undefined: timer and MD_WAIT logic SHALL be absent, id_md_start and id_md_use SHALL be ignored, md_busy SHALL be tied 0, and state SHALL be constant RUN.

Structure
REQ-036 State encodings (RUN, MD_WAIT) and the default MD_CYCLES SHALL live in shared package pipe_ctrl_pkg.
REQ-037 The mult/div down-counter SHALL be sub-module md_timer with ports load, value, busy, done.

Verification
REQ-038 The bench SHALL cover: ex_mem_read=1, ex_rt=5, id_rs=5 -> that cycle pc_write=0, ifid_write=0, idex_bubble=1, stall_cnt+1.
REQ-039 The bench SHALL cover: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall.
REQ-040 The bench SHALL cover: load-use plus ex_branch_taken in the same cycle -> ifid_flush=1, pc_write=1, flush_cnt+1, stall_cnt unchanged.
REQ-041 The bench SHALL cover: MD_CYCLES=4, id_md_start pulse, then id_md_use held high -> md_busy high for 4 cycles, stalls in those 4 cycles, RUN after.
REQ-042 The bench SHALL cover: rst pulled low in the 2nd MD_WAIT cycle -> immediate state=RUN, md_busy=0, counters 0.
REQ-043 The bench SHALL cover: 70000 forced stalls with STAT_W=16 -> stall_cnt holds at 0xFFFF.
